// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receiver state encoding, frame size and timing defaults
package ps2_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} ps2_state_e;
  localparam int PS2_FRAME_BITS  = 11;
  localparam int PS2_DATA_W      = PS2_FRAME_BITS - 3;
  localparam int PS2_SYNC_STAGES = 2;
  localparam int PS2_FILTER_LEN  = 8;
  localparam int PS2_TIMEOUT_CYC = 100000;
endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: small synchronous FIFO for decoded PS/2 words with flush
module ps2_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr_en, rd_en;
  assign full     = cnt_q == CW'(FIFO_DEPTH);
  assign empty    = cnt_q == '0;
  assign pop_data = mem_q[rd_q];
  // a full FIFO still accepts a write when the head is popped in the same cycle
  always_comb begin
    rd_en = pop & ~empty;
    wr_en = push & (~full | rd_en);
    mem_d = mem_q;
    if (wr_en) mem_d[wr_q] = push_data;
    wr_d  = flush ? '0 : wr_q + AW'(wr_en);
    rd_d  = flush ? '0 : rd_q + AW'(rd_en);
    cnt_d = flush ? '0 : cnt_q + CW'(wr_en) - CW'(rd_en);
  end
  // storage and pointer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host frame receiver with deglitch, timeout and output FIFO
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int DATA_W      = PS2_DATA_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = PS2_SYNC_STAGES,
  parameter int FILTER_LEN  = PS2_FILTER_LEN,
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              ps2clk,
  input  logic              ps2data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              timeout_err,
  output logic              overflow
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int BW = $clog2(DATA_W);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic flt_clk_q, flt_clk_d, strobe_q, strobe_d, bit_q, bit_d;
  ps2_state_e state_q, state_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic tmo_hit, stop_now, parity_ok;
  logic push_q, push_d, parity_err_q, parity_err_d, frame_err_q, frame_err_d;
  logic timeout_err_q, timeout_err_d, overflow_q, overflow_d;
  logic fifo_full, fifo_empty, pop;
  assign tmo_hit     = tmo_q == TW'(TIMEOUT_CYC);
  assign busy        = state_q != ST_IDLE;
  assign rx_valid    = ~fifo_empty;
  assign pop         = rx_valid & rx_ready;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;
  assign overflow    = overflow_q;
  // synchronise both pins, accept a new ps2clk level only after FILTER_LEN equal samples
  always_comb begin
    clk_sync_d = (clk_sync_q << 1) | SYNC_STAGES'(ps2clk);
    dat_sync_d = (dat_sync_q << 1) | SYNC_STAGES'(ps2data);
    flt_cnt_d  = (clk_sync_q[SYNC_STAGES-1] != flt_clk_q) ? flt_cnt_q + 1'b1 : '0;
    flt_clk_d  = flt_clk_q;
    if (flt_cnt_d == FW'(FILTER_LEN)) begin
      flt_clk_d = clk_sync_q[SYNC_STAGES-1];
      flt_cnt_d = '0;
    end
    strobe_d = flt_clk_q & ~flt_clk_d;
    bit_d    = dat_sync_q[SYNC_STAGES-1];
  end
  // front-end registers idle high like the released bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      flt_cnt_q  <= '0;
      flt_clk_q  <= 1'b1;
      strobe_q   <= 1'b0;
      bit_q      <= 1'b1;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      flt_cnt_q  <= flt_cnt_d;
      flt_clk_q  <= flt_clk_d;
      strobe_q   <= strobe_d;
      bit_q      <= bit_d;
    end
  end
  // frame state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else state_q <= state_d;
  end
  // frame sequencing on bit strobes; disable and timeout force idle
  always_comb begin
    state_d = state_q;
    if (!en || tmo_hit) state_d = ST_IDLE;
    else if (strobe_q)
      case (state_q)
        ST_IDLE:   state_d = bit_q ? ST_IDLE : ST_DATA;
        ST_DATA:   state_d = (bitcnt_q == BW'(DATA_W - 1)) ? ST_PARITY : ST_DATA;
        ST_PARITY: state_d = ST_STOP;
        default:   state_d = ST_IDLE;
      endcase
  end
  // shift register, bit counter, parity capture and inter-bit timeout counter
  always_comb begin
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tmo_d    = (!en || strobe_q || state_q == ST_IDLE || tmo_hit) ? '0 : tmo_q + 1'b1;
    if (strobe_q && state_q == ST_IDLE) begin
      bitcnt_d = '0;
      shift_d  = '0;
    end
    if (strobe_q && state_q == ST_DATA) begin
      shift_d[bitcnt_q] = bit_q;
      bitcnt_d          = bitcnt_q + 1'b1;
    end
    if (strobe_q && state_q == ST_PARITY) par_d = bit_q;
  end
  // stop-bit verdict; a bad stop bit outranks a bad parity bit
  always_comb begin
    parity_ok     = ^{par_q, shift_q};
    stop_now      = strobe_q & (state_q == ST_STOP) & en & ~tmo_hit;
    push_d        = stop_now & bit_q & parity_ok;
    frame_err_d   = stop_now & ~bit_q;
    parity_err_d  = stop_now & bit_q & ~parity_ok;
    timeout_err_d = en & tmo_hit;
    overflow_d    = en & push_q & fifo_full & ~pop;
  end
  // datapath and single-cycle status pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitcnt_q      <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      tmo_q         <= '0;
      push_q        <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      tmo_q         <= tmo_d;
      push_q        <= push_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
      overflow_q    <= overflow_d;
    end
  end
  ps2_rx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (~en),
    .push      (push_q & en),
    .push_data (shift_q),
    .pop       (pop),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame: directed self-checking bench for the PS/2 frame receiver
module tb_ps2_rx_frame;
  localparam int HALF = 40;
  localparam int TMO  = 500;
  logic clk = 1'b0, reset_n = 1'b0, en = 1'b1, ps2clk = 1'b1, ps2data = 1'b1, rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, busy, parity_err, frame_err, timeout_err, overflow;
  int tests = 0, fails = 0;
  int n_perr = 0, n_ferr = 0, n_tmo = 0, n_ovf = 0, n_multi = 0, n_vcyc = 0;
  logic [7:0] got[$];

  ps2_rx_frame #(.DATA_W(8), .FIFO_DEPTH(4), .SYNC_STAGES(2), .FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .ps2clk(ps2clk), .ps2data(ps2data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy),
    .parity_err(parity_err), .frame_err(frame_err), .timeout_err(timeout_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // observe pulses and accepted words midway between active edges
  always @(negedge clk) begin
    n_perr += int'(parity_err);
    n_ferr += int'(frame_err);
    n_tmo  += int'(timeout_err);
    n_ovf  += int'(overflow);
    n_vcyc += int'(rx_valid);
    if (int'(parity_err) + int'(frame_err) + int'(timeout_err) + int'(overflow) > 1) n_multi++;
    if (rx_valid && rx_ready) got.push_back(rx_data);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int errs();
    return n_perr + n_ferr + n_tmo + n_ovf;
  endfunction

  function automatic logic [31:0] word(input int i);
    return (i < got.size()) ? 32'(got[i]) : 'x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2data = b;
    if (glitch) begin
      cyc(10); ps2clk = 1'b0; cyc(3); ps2clk = 1'b1; cyc(HALF - 13);
    end else cyc(HALF);
    ps2clk = 1'b0;
    cyc(HALF);
    ps2clk = 1'b1;
  endtask

  // start, 8 data LSB first, odd parity (optionally flipped), stop
  task automatic send_frame(input logic [7:0] d, input bit pflip, input logic stopb,
                            input int gbit, input int nbits, input bit pop_on_push);
    logic [10:0] f;
    f = {stopb, (~^d) ^ pflip, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == 10 && pop_on_push) begin
        ps2data = f[i];
        cyc(HALF);
        ps2clk = 1'b0;
        for (int k = 0; k < 30 && busy; k++) cyc(1);
        chk("push_cycle_busy_low", busy, 0);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
        cyc(HALF);
        ps2clk = 1'b1;
      end else send_bit(f[i], i == gbit);
    end
    ps2data = 1'b1;
    cyc(HALF);
  endtask

  initial begin
    int e0, q0, v0, t0, o0, p0, f0;
    cyc(3);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {parity_err, frame_err, timeout_err, overflow}, 0);
    reset_n = 1'b1;
    cyc(20);

    e0 = errs(); q0 = got.size(); v0 = n_vcyc;
    send_frame(8'h1C, 0, 1, -1, 11, 0);
    chk("t1_count", got.size() - q0, 1);
    chk("t1_data", word(q0), 8'h1C);
    chk("t1_valid_cycles", n_vcyc - v0, 1);
    chk("t1_no_errs", errs() - e0, 0);
    chk("t1_busy", busy, 0);

    e0 = errs(); q0 = got.size(); p0 = n_perr;
    send_frame(8'h1C, 1, 1, -1, 11, 0);
    chk("t2_parity_err", n_perr - p0, 1);
    chk("t2_only_one_err", errs() - e0, 1);
    chk("t2_no_word", got.size() - q0, 0);
    send_frame(8'hF0, 0, 1, -1, 11, 0);
    chk("t2_f0_data", word(q0), 8'hF0);
    e0 = errs(); f0 = n_ferr; q0 = got.size();
    send_frame(8'h1C, 0, 0, -1, 11, 0);
    chk("t2_frame_err", n_ferr - f0, 1);
    send_frame(8'h1C, 1, 0, -1, 11, 0);
    chk("t2_both_bad_frame_err", n_ferr - f0, 2);
    chk("t2_both_bad_total", errs() - e0, 2);
    chk("t2_bad_no_word", got.size() - q0, 0);

    e0 = errs(); t0 = n_tmo; q0 = got.size();
    send_frame(8'h0F, 0, 1, -1, 5, 0);
    cyc(400);
    chk("t3_busy_before_tmo", busy, 1);
    chk("t3_no_early_tmo", n_tmo - t0, 0);
    cyc(60);
    chk("t3_timeout_err", n_tmo - t0, 1);
    chk("t3_busy_after", busy, 0);
    chk("t3_only_tmo", errs() - e0, 1);
    send_frame(8'hAA, 0, 1, -1, 11, 0);
    chk("t3_aa_data", word(q0), 8'hAA);
    chk("t3_aa_count", got.size() - q0, 1);

    rx_ready = 1'b0;
    o0 = n_ovf; q0 = got.size();
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 0, 1, -1, 11, 0);
    chk("t4_valid_full", rx_valid, 1);
    chk("t4_head", rx_data, 8'h01);
    chk("t4_no_ovf_yet", n_ovf - o0, 0);
    send_frame(8'h05, 0, 1, -1, 11, 0);
    chk("t4_overflow", n_ovf - o0, 1);
    chk("t4_head_stable", rx_data, 8'h01);
    rx_ready = 1'b1;
    cyc(10);
    chk("t4_drain_count", got.size() - q0, 4);
    for (int i = 0; i < 4; i++) chk("t4_drain_word", word(q0 + i), i + 1);
    chk("t4_empty", rx_valid, 0);

    rx_ready = 1'b0;
    o0 = n_ovf; q0 = got.size();
    for (int i = 1; i <= 4; i++) send_frame(8'h10 + 8'(i), 0, 1, -1, 11, 0);
    send_frame(8'h15, 0, 1, -1, 11, 1);
    chk("t4b_no_overflow", n_ovf - o0, 0);
    chk("t4b_one_pop", got.size() - q0, 1);
    rx_ready = 1'b1;
    cyc(10);
    chk("t4b_drain_count", got.size() - q0, 5);
    for (int i = 0; i < 5; i++) chk("t4b_word", word(q0 + i), 32'h11 + i);

    e0 = errs(); q0 = got.size();
    ps2data = 1'b0;
    cyc(5); ps2clk = 1'b0; cyc(3); ps2clk = 1'b1; cyc(20);
    chk("t5_idle_glitch_busy", busy, 0);
    ps2data = 1'b1;
    cyc(20);
    send_frame(8'h3C, 0, 1, 4, 11, 0);
    chk("t5_glitch_data", word(q0), 8'h3C);
    chk("t5_glitch_count", got.size() - q0, 1);
    chk("t5_no_errs", errs() - e0, 0);

    rx_ready = 1'b0;
    send_frame(8'h21, 0, 1, -1, 11, 0);
    send_frame(8'h22, 0, 1, -1, 11, 0);
    chk("t6_two_buffered", rx_valid, 1);
    e0 = errs(); q0 = got.size();
    send_frame(8'h00, 0, 1, -1, 4, 0);
    chk("t6_busy_mid", busy, 1);
    en = 1'b0;
    cyc(2);
    chk("t6_flush_valid", rx_valid, 0);
    chk("t6_abort_busy", busy, 0);
    cyc(TMO + 50);
    chk("t6_no_pulses", errs() - e0, 0);
    en = 1'b1;
    rx_ready = 1'b1;
    cyc(5);
    send_frame(8'h5A, 0, 1, -1, 11, 0);
    chk("t6_en_5a_count", got.size() - q0, 1);
    chk("t6_en_5a_data", word(q0), 8'h5A);

    rx_ready = 1'b0;
    send_frame(8'h33, 0, 1, -1, 11, 0);
    send_frame(8'h00, 0, 1, -1, 6, 0);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", rx_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_data", rx_data, 0);
    chk("t6_rst_pulses", {parity_err, frame_err, timeout_err, overflow}, 0);
    cyc(3);
    reset_n = 1'b1;
    cyc(10);
    q0 = got.size();
    rx_ready = 1'b1;
    send_frame(8'h5A, 0, 1, -1, 11, 0);
    chk("t6_rst_5a_count", got.size() - q0, 1);
    chk("t6_rst_5a_data", word(q0), 8'h5A);

    chk("exclusive_pulses", n_multi, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
